// File: rtl/snowball_mem_responder_pkg.sv
// Shared definitions for the snowball SRAM responder: FSM encoding, debug view
// and the read-latency default used by the responder and its delay line.
package snowball_mem_responder_pkg;

  localparam int unsigned SNOWBALL_READ_LAT = 6;
  localparam int unsigned RD_LAT_MIN        = 3;
  localparam int unsigned RD_LAT_MAX        = 14;
  localparam int unsigned RD_CNT_W          = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ACK     = 3'd1,
    ST_HOLD    = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_RD_W0   = 3'd4,
    ST_RD_W1   = 3'd5,
    ST_DMA     = 3'd6
  } state_t;

  // Debug view: FSM state plus the latched request.
  typedef struct packed {
    state_t      state;
    logic        req_we;
    logic [31:0] req_addr;
  } dbg_t;

  // Counter preload for a given read latency; out-of-range values are clamped
  // so the delay line can never wrap or skip the companion-word cycle.
  function automatic logic [RD_CNT_W-1:0] rd_load_value(input int unsigned lat);
    int unsigned l;
    l = lat;
    if (l < RD_LAT_MIN) l = RD_LAT_MIN;
    if (l > RD_LAT_MAX) l = RD_LAT_MAX;
    return RD_CNT_W'(l - 1);
  endfunction

endpackage

// File: rtl/snowball_rd_timer.sv
// Read-latency delay line: loaded while a read is acknowledged, it flags the
// cycle the SRAM address moves to the companion word and the last wait cycle.
module snowball_rd_timer
  import snowball_mem_responder_pkg::*;
#(
  parameter int unsigned READ_LAT = SNOWBALL_READ_LAT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic switch_word,
  output logic last_wait
);

  localparam logic [RD_CNT_W-1:0] LOAD_VAL = rd_load_value(READ_LAT);

  logic [RD_CNT_W-1:0] count;

  // In cycle ACK+k the count equals READ_LAT-k; it idles at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  // Address of the latched word is seen by the SRAM through ACK+READ_LAT-2,
  // the companion word in ACK+READ_LAT-1; data is registered one cycle later.
  assign switch_word = (count == RD_CNT_W'(2));
  assign last_wait   = (count == RD_CNT_W'(1));

endmodule

// File: rtl/snowball_mem_responder.sv
// CPU-side SRAM responder: acknowledges single-word requests, returns reads as
// a word pair after a fixed latency and hands the SRAM to a DMA master on request.
module snowball_mem_responder
  import snowball_mem_responder_pkg::*;
#(
  parameter int unsigned READ_LAT = SNOWBALL_READ_LAT,
  parameter int unsigned AW       = 16
) (
  input  logic          MCU_CLK,
  input  logic          RST,
  input  logic [31:0]   mem_addr,
  input  logic          mem_we,
  input  logic          mem_do_act,
  input  logic [31:0]   mem_dataintomem,
  output logic          mem_ack,
  output logic [31:0]   mem_datafrommem,
  output logic          dma_mcu_access,
  input  logic          dma_req,
  output logic          dma_gnt,
  output logic [AW-1:0] sram_addr,
  output logic          sram_we,
  output logic [31:0]   sram_wdata,
  input  logic [31:0]   sram_rdata,
  output dbg_t          dbg
);

  // Handshake: the initiator raises mem_do_act only while dma_mcu_access is
  // high and holds it until the cycle after it sees the one-cycle mem_ack;
  // mem_do_act is sampled in IDLE only, so the trailing strobe is harmless.

  state_t      state;
  state_t      state_next;
  logic [31:0] req_addr;
  logic        req_we;
  logic        accept;
  logic        rd_load;
  logic        rd_switch;
  logic        rd_last;
  logic        rd_capture;

  // dma_mcu_access is always high in IDLE, so it needs no term here.
  assign accept     = (state == ST_IDLE) && mem_do_act;
  assign rd_capture = ((state == ST_RD_WAIT) && rd_last) || (state == ST_RD_W0);

  always_ff @(posedge MCU_CLK or negedge RST) begin
    if (!RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    mem_ack    = 1'b0;
    dma_gnt    = 1'b0;
    rd_load    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_next = ST_ACK;
        end else if (dma_req) begin
          state_next = ST_DMA;
        end
      end
      ST_ACK: begin
        mem_ack    = 1'b1;
        rd_load    = !req_we;
        state_next = req_we ? ST_HOLD : ST_RD_WAIT;
      end
      ST_HOLD: begin
        state_next = ST_IDLE;
      end
      ST_RD_WAIT: begin
        if (rd_last) begin
          state_next = ST_RD_W0;
        end
      end
      ST_RD_W0: begin
        state_next = ST_RD_W1;
      end
      ST_RD_W1: begin
        state_next = ST_IDLE;
      end
      ST_DMA: begin
        dma_gnt = 1'b1;
        if (!dma_req) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign dma_mcu_access = !dma_gnt;

  always_ff @(posedge MCU_CLK or negedge RST) begin
    if (!RST) begin
      req_addr <= '0;
      req_we   <= 1'b0;
    end else if (accept) begin
      req_addr <= mem_addr;
      req_we   <= mem_we;
    end
  end

  // SRAM port is registered: a request accepted in IDLE presents its word
  // address (and write strobe) during ACK.
  always_ff @(posedge MCU_CLK or negedge RST) begin
    if (!RST) begin
      sram_addr  <= '0;
      sram_we    <= 1'b0;
      sram_wdata <= '0;
    end else begin
      sram_we <= accept && mem_we;
      if (accept) begin
        sram_addr  <= mem_addr[AW+1:2];
        sram_wdata <= mem_dataintomem;
      end else if ((state == ST_RD_WAIT) && rd_switch) begin
        // Companion word: toggle only address bit 2, so the last odd word
        // pairs with the even word just below it.
        sram_addr <= req_addr[AW+1:2] ^ AW'(1);
      end
    end
  end

  always_ff @(posedge MCU_CLK or negedge RST) begin
    if (!RST) begin
      mem_datafrommem <= '0;
    end else if (rd_capture) begin
      mem_datafrommem <= sram_rdata;
    end else begin
      mem_datafrommem <= '0;
    end
  end

  snowball_rd_timer #(
    .READ_LAT (READ_LAT)
  ) u_rd_timer (
    .clk         (MCU_CLK),
    .rst_n       (RST),
    .load        (rd_load),
    .switch_word (rd_switch),
    .last_wait   (rd_last)
  );

  assign dbg.state    = state;
  assign dbg.req_we   = req_we;
  assign dbg.req_addr = req_addr;

endmodule

// File: doc/snowball_mem_responder.md
SNOWBALL_MEM_RESPONDER -- requirements
Module: snowball_mem_responder

Interface
REQ-001 Parameter READ_LAT, default 6: cycles from the ack cycle to the first read word on mem_datafrommem; legal range 3..14.
REQ-002 Parameter AW, default 16: SRAM word-address width.
REQ-003 MCU_CLK  in  1  sole clock; all state changes on its rising edge.
REQ-004 RST  in  1  asynchronous, active-low reset.
REQ-005 mem_addr  in  32  byte address from the initiator; bits [AW+1:2] select the word.
REQ-006 mem_we  in  1  write request; low means read.
REQ-007 mem_do_act  in  1  request strobe, held high by the initiator until one cycle after it sees ack.
REQ-008 mem_dataintomem  in  32  write data.
REQ-009 mem_ack  out  1  one-cycle acknowledge.
REQ-010 mem_datafrommem  out  32  read data.
REQ-011 dma_mcu_access  out  1  high means the CPU port may drive mem_do_act.
REQ-012 dma_req  in  1  DMA requests ownership of the SRAM.
REQ-013 dma_gnt  out  1  DMA owns the SRAM.
REQ-014 sram_addr  out  AW, sram_we  out  1, sram_wdata  out  32, sram_rdata  in  32: synchronous SRAM port; rdata is valid one cycle after addr.

Function
REQ-015 FSM states: IDLE, ACK, HOLD, RD_WAIT, RD_W0, RD_W1, DMA.
REQ-016 IDLE with mem_do_act=1 and dma_mcu_access=1 in cycle R: latch mem_addr, mem_we and mem_dataintomem; go to ACK.
REQ-017 ACK (cycle A=R+1): mem_ack=1; for a write, sram_we=1 with the latched address and data.
REQ-018 ACK exits to HOLD for a write and to RD_WAIT for a read.
REQ-019 HOLD lasts one cycle (A+1), ignores mem_do_act, then returns to IDLE.
REQ-020 Read: SRAM reads of the latched word and of the companion word (addr bit 2 inverted) are issued so that mem_datafrommem carries the latched word in cycle A+READ_LAT and the companion word in A+READ_LAT+1.
REQ-021 Read: mem_datafrommem is held stable for exactly one cycle per word (states RD_W0, RD_W1); it is zero otherwise.
REQ-022 Read: the FSM returns to IDLE in A+READ_LAT+2; mem_do_act is ignored in every non-IDLE state.
REQ-023 mem_ack is never high outside ACK and never high for two consecutive cycles.
REQ-024 Arbitration in IDLE: mem_do_act takes priority over dma_req in the same cycle.
REQ-025 IDLE with dma_req=1 and mem_do_act=0: go to DMA; dma_mcu_access=0 and dma_gnt=1 from the next cycle.
REQ-026 DMA state: the module drives no SRAM write; on dma_req=0, dma_gnt falls and dma_mcu_access rises on the next edge, then IDLE.
REQ-027 dma_req rising during a CPU transaction: the grant is deferred until the FSM reaches IDLE.
REQ-028 Word address wraps modulo 2^AW; the companion word of the last odd word is the preceding even word (bit-2 toggle only).

Reset
REQ-029 RST low asynchronously forces IDLE, mem_ack=0, mem_datafrommem=0, dma_mcu_access=1, dma_gnt=0, sram_we=0, sram_addr=0, sram_wdata=0, and clears latched request state.
REQ-030 Reset mid-transaction aborts it with no ack and no SRAM write; after release the FSM is in IDLE.

Structure
REQ-031 FSM state encodings and the READ_LAT default go in the shared snowball package.
REQ-032 The read-latency delay line, a counter loaded at ACK, is a natural sub-module named snowball_rd_timer; everything else is flat.

Verification
REQ-033 Write: addr 0x40, data 0xDEADBEEF, we=1 -> ack in R+1, SRAM word 0x10 = 0xDEADBEEF, IDLE at R+3.
REQ-034 Read: word 0x10=0x11111111, word 0x11=0x22222222, request addr 0x40 read -> 0x11111111 at A+6, 0x22222222 at A+7, single ack.
REQ-035 Odd read: addr 0x44 -> 0x22222222 at A+6, then 0x11111111 at A+7.
REQ-036 Collision: dma_req and mem_do_act both rise in one IDLE cycle -> CPU acked; dma_gnt=1 only after the transaction ends; dma_mcu_access=0 while granted.
REQ-037 RST pulsed low at A+3 of a read -> no further data, outputs at reset values, next request serviced normally.
REQ-038 mem_do_act held high through HOLD -> no second ack.
